// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer
//   Partial-sum buffer between the corelet OFIFO and the readout path. Holds a
//   DEPTH x (COL*PSUM_BW) array and accumulates incoming rows in place with a
//   read-modify-write pipeline. Also provides a first-pass overwrite (LOAD),
//   ordered reads with optional ReLU, and a hardware clear sweep.
//
//   Build option: define PSUM_SAT_EN to saturate ACC per lane. Without it,
//   ACC wraps modulo 2^PSUM_BW.
//
//   Ports
//     clk, reset           clock (rising edge), async active-high reset
//     in_valid/in_ready    accumulate/load handshake
//     in_first             1: LOAD (overwrite row), 0: ACC (row += in_data)
//     in_addr, in_data     target row and COL signed lanes of PSUM_BW bits
//     rd_req/rd_ready      read handshake (writes win in the same cycle)
//     rd_addr, relu_en     row to read, clamp negative lanes on rd_data
//     rd_valid, rd_data    one-cycle read result, two cycles after the request
//     clear, busy          start clear sweep (sampled in IDLE), sweep active
//
//   state    | meaning
//   ST_IDLE  | accepting requests, clear starts a sweep
//   ST_CLEAR | writing zero to one row per cycle, requests blocked
module psum_accum_buffer #(
  parameter int COL      = 8,
  parameter int PSUM_BW  = 16,
  parameter int DEPTH    = 256,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int DW      = COL * PSUM_BW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DW-1:0]     in_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              relu_en,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  input  logic              clear,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DW-1:0]     mem [DEPTH];

  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] req_addr;

  logic              s1_vld, s1_rd, s1_first, s1_relu, s1_inr;
  logic [ADDR_W-1:0] s1_addr;
  logic [DW-1:0]     s1_data, s1_mem;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DW-1:0]     mem_wdata;

  logic              byp_vld_q;
  logic [ADDR_W-1:0] byp_addr_q;
  logic [DW-1:0]     byp_data_q;

  logic [DW-1:0]     operand, result, rd_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !clear;
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ROW)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_ready = in_ready && !in_valid;
  assign wr_acc   = in_valid && in_ready;
  assign rd_acc   = rd_req && rd_ready;
  assign req_addr = wr_acc ? in_addr : rd_addr;

  // The S1 op always lands at the edge it leaves S1, so an accepted op that
  // coincides with clear is written before the sweep's first row.
  always_comb begin
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else begin
      mem_we    = s1_vld && !s1_rd && s1_inr;
      mem_waddr = s1_addr;
      mem_wdata = result;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    s1_mem     <= mem[req_addr];
    s1_rd      <= !wr_acc;
    s1_first   <= in_first;
    s1_relu    <= relu_en;
    s1_addr    <= req_addr;
    s1_data    <= in_data;
    s1_inr     <= {1'b0, req_addr} < DEPTH_L;
    byp_addr_q <= mem_waddr;
    byp_data_q <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      byp_vld_q <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      s1_vld    <= wr_acc || rd_acc;
      byp_vld_q <= mem_we;
      rd_valid  <= s1_vld && s1_rd;
      if (s1_vld && s1_rd)
        rd_data <= s1_inr ? rd_word : '0;
    end
  end

  // The synchronous array read misses a write landing on the same edge it
  // samples; the registered copy of that write covers the gap.
  assign operand = (byp_vld_q && byp_addr_q == s1_addr) ? byp_data_q : s1_mem;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic [PSUM_BW-1:0] a, b, acc;
    logic [PSUM_BW:0]   sum;

    assign a   = operand[i*PSUM_BW +: PSUM_BW];
    assign b   = s1_data[i*PSUM_BW +: PSUM_BW];
    assign sum = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};

`ifdef PSUM_SAT_EN
    // Sign bits disagree only when the true sum left the lane range.
    always_comb begin
      if (sum[PSUM_BW] != sum[PSUM_BW-1])
        acc = sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
      else
        acc = sum[PSUM_BW-1:0];
    end
`else
    assign acc = sum[PSUM_BW-1:0];
`endif

    assign result[i*PSUM_BW +: PSUM_BW]  = s1_first ? b : acc;
    assign rd_word[i*PSUM_BW +: PSUM_BW] = (s1_relu && a[PSUM_BW-1]) ? '0 : a;
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
`timescale 1ns/1ps
module tb_psum_accum_buffer;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_first;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rd_req, rd_ready, relu_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          clear, busy;

  always #5 clk = ~clk;

  psum_accum_buffer #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_addr(in_addr), .in_data(in_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .relu_en(relu_en),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .clear(clear), .busy(busy)
  );

  // Reference: the buffer seen as a plain array where every accepted op takes
  // effect in acceptance order.
  logic [BW-1:0] mdl [DEPTH][COL];
  int            n_checks = 0;
  int            n_err    = 0;
  logic          acc_v = 1'b0, p_v = 1'b0;
  logic [DW-1:0] acc_d = '0, p_d = '0;

  function automatic logic [BW-1:0] lane_acc(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[BW-1:0];
  endfunction

  task automatic mdl_write(input logic first, input int addr, input logic [DW-1:0] d);
    for (int i = 0; i < COL; i++)
      mdl[addr][i] = first ? d[i*BW +: BW] : lane_acc(mdl[addr][i], d[i*BW +: BW]);
  endtask

  function automatic logic [DW-1:0] mdl_read(input int addr, input logic relu);
    logic [DW-1:0] r;
    logic [BW-1:0] v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      v = mdl[addr][i];
      if (relu && v[BW-1]) v = '0;
      r[i*BW +: BW] = v;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] splat(input logic [BW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the read port with the expected pulse train.
  task automatic step();
    logic          ev;
    logic [DW-1:0] ed;
    @(posedge clk); #1;
    ev = p_v; ed = p_d;
    p_v = acc_v; p_d = acc_d; acc_v = 1'b0;
    chk("rd_valid", DW'(rd_valid), DW'(ev));
    if (ev) chk("rd_data", rd_data, ed);
  endtask

  task automatic wr(input logic first, input int addr, input logic [DW-1:0] d);
    in_valid = 1'b1; in_first = first; in_addr = AW'(addr); in_data = d;
    #1;
    chk("wr_in_ready", DW'(in_ready), DW'(1'b1));
    mdl_write(first, addr, d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input int addr, input logic relu, input logic [DW-1:0] exp);
    rd_req = 1'b1; rd_addr = AW'(addr); relu_en = relu;
    #1;
    chk("rd_ready", DW'(rd_ready), DW'(1'b1));
    acc_v = 1'b1; acc_d = mdl_read(addr, relu);
    step();
    rd_req = 1'b0;
    step();
    chk(tag, rd_data, exp);
  endtask

  task automatic do_clear();
    int   n;
    logic ir_bad;
    clear = 1'b1;
    #1;
    chk("clear_in_ready", DW'(in_ready), DW'(1'b0));
    chk("clear_rd_ready", DW'(rd_ready), DW'(1'b0));
    step();
    clear = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
    n = 0; ir_bad = 1'b0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      if (in_ready !== 1'b0) ir_bad = 1'b1;
      step();
    end
    chk("busy_cycles", DW'(n), DW'(DEPTH));
    chk("in_ready_low_while_busy", DW'(ir_bad), DW'(1'b0));
    chk("in_ready_after_clear", DW'(in_ready), DW'(1'b1));
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < COL; i++) mdl[r][i] = '0;
  endtask

  initial begin
    logic [DW-1:0] d, e;
    int            op;
    logic          w, r;

    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_addr = '0; in_data = '0;
    rd_req = 1'b0; rd_addr = '0; relu_en = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", DW'(rd_valid), DW'(1'b0));
    chk("reset_rd_data", rd_data, '0);
    chk("reset_busy", DW'(busy), DW'(1'b0));
    reset = 1'b0;
    step();
    chk("idle_in_ready", DW'(in_ready), DW'(1'b1));

    // 1: clear sweep, then rows at both ends read back zero
    do_clear();
    rd_expect("t1_row0", 0, 1'b0, '0);
    rd_expect("t1_row255", 255, 1'b0, '0);

    // 2: LOAD then ACC on consecutive cycles
    wr(1'b1, 5, splat(16'd3));
    wr(1'b0, 5, splat(16'd4));
    rd_expect("t2_fwd", 5, 1'b0, splat(16'd7));

    // 3: four back-to-back ACCs, read the cycle after
    repeat (4) wr(1'b0, 9, DW'(1));
    rd_expect("t3_b2b", 9, 1'b0, DW'(4));

    // 4: ReLU only on the read path
    d = '0; d[31:16] = 16'hFFFB; d[15:0] = 16'd6;
    wr(1'b1, 2, d);
    rd_expect("t4_relu", 2, 1'b1, DW'(6));
    rd_expect("t4_norelu", 2, 1'b0, d);

    // 5: overflow at both lane extremes
    d = '0; d[15:0] = 16'h7FFF; d[31:16] = 16'h8000;
    wr(1'b1, 7, d);
    d = '0; d[15:0] = 16'h0001; d[31:16] = 16'hFFFF;
    wr(1'b0, 7, d);
    e = '0;
`ifdef PSUM_SAT_EN
    e[15:0] = 16'h7FFF; e[31:16] = 16'h8000;
`else
    e[15:0] = 16'h8000; e[31:16] = 16'h7FFF;
`endif
    rd_expect("t5_ovf", 7, 1'b0, e);

    // 6: write beats read; clear beats write
    in_valid = 1'b1; in_first = 1'b1; in_addr = 8'd20; in_data = splat(16'd55);
    rd_req = 1'b1; rd_addr = 8'd5; relu_en = 1'b0;
    #1;
    chk("t6_rd_ready", DW'(rd_ready), DW'(1'b0));
    chk("t6_in_ready", DW'(in_ready), DW'(1'b1));
    mdl_write(1'b1, 20, splat(16'd55));
    step();
    in_valid = 1'b0; rd_req = 1'b0;
    rd_expect("t6_write_won", 20, 1'b0, splat(16'd55));
    in_valid = 1'b1; in_first = 1'b1; in_addr = 8'd21; in_data = splat(16'd77);
    do_clear();
    rd_expect("t6_clear_won", 21, 1'b0, '0);

    // Reset discards an op sitting in the pipeline
    in_valid = 1'b1; in_first = 1'b1; in_addr = 8'd3; in_data = splat(16'h1234);
    #1;
    chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst_rd_valid", DW'(rd_valid), DW'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0; acc_v = 1'b0; p_v = 1'b0;
    step();
    rd_expect("rst_discard", 3, 1'b0, '0);

    // Reset aborts a sweep
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    chk("sweep_busy", DW'(busy), DW'(1'b1));
    reset = 1'b1;
    #1;
    chk("sweep_abort_busy", DW'(busy), DW'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0; acc_v = 1'b0; p_v = 1'b0;
    step();
    chk("sweep_abort_in_ready", DW'(in_ready), DW'(1'b1));
    rd_expect("sweep_abort_row", 9, 1'b0, '0);

    // Random mix of LOAD/ACC/read on a few hot rows
    for (int k = 0; k < 300; k++) begin
      op = int'($urandom_range(0, 3));
      w = op[0]; r = op[1];
      in_valid = w; rd_req = r;
      in_first = ($urandom_range(0, 3) == 0);
      in_addr  = AW'($urandom_range(0, 7));
      rd_addr  = AW'($urandom_range(0, 7));
      relu_en  = 1'($urandom_range(0, 1));
      for (int i = 0; i < COL; i++)
        in_data[i*BW +: BW] = ($urandom_range(0, 3) == 0) ? BW'($urandom)
                                                         : BW'($urandom_range(0, 40)) - 16'd20;
      #1;
      chk("rnd_in_ready", DW'(in_ready), DW'(1'b1));
      chk("rnd_rd_ready", DW'(rd_ready), DW'(!w));
      if (w) mdl_write(in_first, int'(in_addr), in_data);
      else if (r) begin
        acc_v = 1'b1;
        acc_d = mdl_read(int'(rd_addr), relu_en);
      end
      step();
    end
    in_valid = 1'b0; rd_req = 1'b0;
    for (int a = 0; a < 8; a++) rd_expect("rnd_final", a, 1'b0, mdl_read(a, 1'b0));
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
